// File: rtl/rect_fill_writer.sv
// Fills an axis-aligned rectangle of the framebuffer with one colour, emitting
// a row-major stream of RAM writes (address = y*FB_W + x) and clipping off-screen pixels.
module rect_fill_writer #(
  parameter int FB_W   = 320,
  parameter int FB_H   = 240,
  parameter int ADDR_W = 17,
  parameter int DATA_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [9:0]        x0,
  input  logic [9:0]        y0,
  input  logic [9:0]        w,
  input  logic [9:0]        h,
  input  logic [DATA_W-1:0] color,
  input  logic              wr_ready,
  output logic              busy,
  output logic              done,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata
);

  localparam int CW = 11;
  localparam int BW = 21;

  typedef enum logic [1:0] {IDLE = 2'd0, INIT = 2'd1, RUN = 2'd2} state_t;

  state_t            state_r;
  logic [CW-1:0]     x0_r, end_x_r, end_y_r, cur_x_r, cur_y_r;
  logic [BW-1:0]     base_r;
  logic [DATA_W-1:0] color_r;

  logic [CW-1:0]     px_s, py_s;
  logic [BW-1:0]     pbase_s;
  logic [ADDR_W-1:0] lin_s;
  logic              wrap_s, last_s, retire_s, in_rng_s;

  // Constant-coefficient shift-and-add: y*FB_W without a multiplier.
  function automatic logic [BW-1:0] row_base(input logic [CW-1:0] y);
    logic [BW-1:0] acc;
    acc = {BW{1'b0}};
    for (int b = 0; b < BW; b++) begin
      if (((FB_W >> b) & 1) != 0) acc = acc + ({{(BW-CW){1'b0}}, y} << b);
      else                        acc = acc;
    end
    return acc;
  endfunction

  // Next pixel to present: the first pixel in INIT, otherwise the successor of the current one.
  always_comb begin
    px_s    = cur_x_r;
    py_s    = cur_y_r;
    pbase_s = base_r;
    wrap_s  = (cur_x_r + 11'd1) == end_x_r;
    if (state_r == INIT) begin
      pbase_s = row_base(cur_y_r);
    end else if (wrap_s) begin
      px_s    = x0_r;
      py_s    = cur_y_r + 11'd1;
      pbase_s = base_r + BW'(FB_W);
    end else begin
      px_s    = cur_x_r + 11'd1;
    end
    last_s   = wrap_s && ((cur_y_r + 11'd1) == end_y_r);
    retire_s = !we || wr_ready;
    in_rng_s = (px_s < CW'(FB_W)) && (py_s < CW'(FB_H));
    lin_s    = ADDR_W'(pbase_s + {{(BW-CW){1'b0}}, px_s});
  end

  // Fill sequencer with registered write port and status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      we      <= 1'b0;
      waddr   <= {ADDR_W{1'b0}};
      wdata   <= {DATA_W{1'b0}};
      x0_r    <= {CW{1'b0}};
      end_x_r <= {CW{1'b0}};
      end_y_r <= {CW{1'b0}};
      cur_x_r <= {CW{1'b0}};
      cur_y_r <= {CW{1'b0}};
      base_r  <= {BW{1'b0}};
      color_r <= {DATA_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          we   <= 1'b0;
          busy <= 1'b0;
          if (start) begin
            x0_r    <= {1'b0, x0};
            cur_x_r <= {1'b0, x0};
            cur_y_r <= {1'b0, y0};
            end_x_r <= {1'b0, x0} + {1'b0, w};
            end_y_r <= {1'b0, y0} + {1'b0, h};
            color_r <= color;
            if (w == 10'd0 || h == 10'd0) done <= 1'b1;
            else                          state_r <= INIT;
          end
        end
        INIT: begin
          busy    <= 1'b1;
          base_r  <= pbase_s;
          we      <= in_rng_s;
          waddr   <= lin_s;
          wdata   <= color_r;
          state_r <= RUN;
        end
        RUN: begin
          if (retire_s) begin
            if (last_s) begin
              state_r <= IDLE;
              busy    <= 1'b0;
              we      <= 1'b0;
              done    <= 1'b1;
            end else begin
              cur_x_r <= px_s;
              cur_y_r <= py_s;
              base_r  <= pbase_s;
              we      <= in_rng_s;
              waddr   <= lin_s;
            end
          end
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
          we      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rect_fill_writer.sv
// Directed and randomized bench for rect_fill_writer; expected writes come from
// a plain nested-loop rectangle model with clipping.
module tb_rect_fill_writer;

  logic        clk = 1'b0;
  logic        rst_n, start, wr_ready;
  logic [9:0]  x0, y0, w, h;
  logic [11:0] color;
  logic        busy, done, we;
  logic [16:0] waddr;
  logic [11:0] wdata;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  rect_fill_writer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .x0(x0), .y0(y0), .w(w), .h(h),
    .color(color), .wr_ready(wr_ready), .busy(busy), .done(done), .we(we),
    .waddr(waddr), .wdata(wdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode 0: ready always 1, mode 1: ready 1,0,1,0..., mode 2: random ready
  task automatic do_fill(input string tag, input int ax0, input int ay0, input int aw,
                         input int ah, input logic [11:0] col, input int mode,
                         input int restart_at);
    int exp_q[$];
    int got_a[$];
    int got_d[$];
    int clipped, c, we0, busy_cyc, budget;
    logic prev_we, prev_rdy;
    logic [16:0] prev_addr;
    logic [11:0] prev_data;
    clipped = 0;
    for (int j = 0; j < ah; j++)
      for (int i = 0; i < aw; i++)
        if (ax0 + i < 320 && ay0 + j < 240) exp_q.push_back((ay0 + j) * 320 + ax0 + i);
        else clipped++;
    budget = 8 * aw * ah + 20;
    x0 = 10'(ax0); y0 = 10'(ay0); w = 10'(aw); h = 10'(ah); color = col;
    start = 1'b1;
    tick();
    start = 1'b0;
    x0 = 10'($urandom); y0 = 10'($urandom); w = 10'($urandom); h = 10'($urandom);
    color = 12'($urandom);
    check({tag, "_init_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_init_we"}, {31'd0, we}, 32'd0);
    tick();
    c = 1; we0 = 0; busy_cyc = 0; prev_we = 1'b0; prev_rdy = 1'b1;
    prev_addr = 17'd0; prev_data = 12'd0;
    while (done !== 1'b1 && c <= budget) begin
      if (busy !== 1'b1) check({tag, "_busy"}, {31'd0, busy}, 32'd1);
      busy_cyc++;
      if (prev_we && !prev_rdy) begin
        check({tag, "_stall_we"}, {31'd0, we}, 32'd1);
        check({tag, "_stall_addr"}, {15'd0, waddr}, {15'd0, prev_addr});
        check({tag, "_stall_data"}, {20'd0, wdata}, {20'd0, prev_data});
      end
      if (!we) we0++;
      if (mode == 0)      wr_ready = 1'b1;
      else if (mode == 1) wr_ready = (c % 2) == 1;
      else                wr_ready = 1'($urandom_range(0, 1));
      if (c == restart_at) begin
        start = 1'b1; x0 = 10'd50; y0 = 10'd60; w = 10'd3; h = 10'd3; color = ~col;
      end else begin
        start = 1'b0;
      end
      if (we && wr_ready) begin
        got_a.push_back(int'(waddr));
        got_d.push_back(int'(wdata));
      end
      prev_we = we; prev_rdy = wr_ready; prev_addr = waddr; prev_data = wdata;
      tick();
      c++;
    end
    start = 1'b0;
    wr_ready = 1'b1;
    check({tag, "_done_seen"}, {31'd0, done}, 32'd1);
    check({tag, "_end_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_end_we"}, {31'd0, we}, 32'd0);
    check({tag, "_nwrites"}, got_a.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < got_a.size(); k++) begin
      check({tag, "_addr"}, got_a[k], exp_q[k]);
      check({tag, "_data"}, got_d[k], {20'd0, col});
    end
    check({tag, "_clipped"}, we0, clipped);
    if (mode == 0) begin
      check({tag, "_done_cycle"}, c, 1 + aw * ah);
      check({tag, "_busy_cycles"}, busy_cyc, aw * ah);
    end
    tick();
    check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int n, g;
    rst_n = 1'b0; start = 1'b0; wr_ready = 1'b1;
    x0 = 10'd0; y0 = 10'd0; w = 10'd0; h = 10'd0; color = 12'd0;
    tick(); tick();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_we", {31'd0, we}, 32'd0);
    check("rst_waddr", {15'd0, waddr}, 32'd0);
    check("rst_wdata", {20'd0, wdata}, 32'd0);
    rst_n = 1'b1;
    tick();

    do_fill("basic", 10, 5, 4, 2, 12'hF00, 0, -1);
    do_fill("stall", 10, 5, 4, 2, 12'hF00, 1, -1);
    do_fill("corner", 318, 239, 4, 3, 12'h0F0, 0, -1);

    // zero-size request completes immediately without writing
    x0 = 10'd3; y0 = 10'd3; w = 10'd0; h = 10'd7; start = 1'b1;
    tick();
    start = 1'b0;
    check("zero_done", {31'd0, done}, 32'd1);
    check("zero_busy", {31'd0, busy}, 32'd0);
    check("zero_we", {31'd0, we}, 32'd0);
    tick();
    check("zero_done_pulse", {31'd0, done}, 32'd0);
    check("zero_busy2", {31'd0, busy}, 32'd0);
    check("zero_we2", {31'd0, we}, 32'd0);

    // reset in the middle of a 5x5 fill
    x0 = 10'd20; y0 = 10'd20; w = 10'd5; h = 10'd5; color = 12'h0AB;
    wr_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    n = 0; g = 0;
    while (n < 3 && g < 50) begin
      if (we) n++;
      tick();
      g++;
    end
    check("mid_writes", n, 3);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mid_rst_we", {31'd0, we}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_done", {31'd0, done}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("post_rst_we", {31'd0, we}, 32'd0);
      check("post_rst_busy", {31'd0, busy}, 32'd0);
    end
    do_fill("after_rst", 20, 20, 5, 5, 12'h0AB, 0, -1);

    do_fill("restart", 100, 100, 4, 2, 12'h00F, 0, 3);
    do_fill("far_clip", 1020, 1018, 5, 3, 12'h123, 0, -1);
    do_fill("edge_row", 0, 239, 3, 2, 12'hABC, 2, -1);

    for (int r = 0; r < 6; r++)
      do_fill("rand", $urandom_range(300, 330), $urandom_range(228, 250),
              $urandom_range(1, 5), $urandom_range(1, 5), 12'($urandom), 2, -1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
